// File: rtl/usb_ep_capture.sv
// Per-endpoint OUT/SETUP packet capture with a registered read port and
// masked SETUP-request comparators for endpoint 0.
module usb_ep_capture #(
    parameter int NUM_EP    = 16,
    parameter int DEPTH     = 8,
    parameter int NUM_MATCH = 4,
    parameter int LW        = $clog2(DEPTH + 1)
) (
    input  logic                         clk48,
    input  logic                         rst_n,
    input  logic                         usb_rst,
    input  logic                         transaction_active,
    input  logic [3:0]                   endpoint,
    input  logic                         setup,
    input  logic                         direction_in,
    input  logic                         data_strobe,
    input  logic [7:0]                   data_out,
    input  logic                         success,
    input  logic [NUM_MATCH*64-1:0]      match_pattern,
    input  logic [NUM_MATCH*64-1:0]      match_mask,
    input  logic [3:0]                   rd_ep,
    input  logic [$clog2(DEPTH)-1:0]     rd_idx,
    output logic [7:0]                   rd_data,
    output logic [LW-1:0]                rd_len,
    output logic                         rd_valid,
    output logic                         pkt_v,
    output logic [3:0]                   pkt_ep,
    output logic [LW-1:0]                pkt_len,
    output logic                         pkt_setup,
    output logic                         ovf,
    output logic                         match_v,
    output logic [$clog2(NUM_MATCH)-1:0] match_idx,
    output logic [NUM_MATCH-1:0]         match_vec
);

    localparam int IW = $clog2(DEPTH);
    localparam int MW = $clog2(NUM_MATCH);
    localparam logic [4:0]    EP_LIM  = 5'(NUM_EP);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] SETUP_L = LW'(8);

    logic          ta_q;
    logic          sync_q;   // a low transaction_active has been seen since reset
    logic          in_txn;
    logic          ovf_txn;
    logic [LW-1:0] count;
    logic [7:0]    stage [DEPTH];
    logic [7:0]    mem   [NUM_EP][DEPTH];
    logic [LW-1:0] len_q [NUM_EP];
    logic [NUM_EP-1:0] valid_q;

    logic          ep_ok;
    logic          rd_ok;
    logic          start;
    logic          end_t;
    logic          accept;
    logic          has_room;
    logic          commit;
    logic          do_match;
    logic [LW-1:0] cnt_eff;
    logic [63:0]   setup_word;
    logic [NUM_MATCH-1:0] hit;
    logic [MW-1:0] low_idx;

    assign ep_ok    = {1'b0, endpoint} < EP_LIM;
    assign rd_ok    = {1'b0, rd_ep} < EP_LIM;
    assign start    = transaction_active & ~ta_q & sync_q;
    assign end_t    = ~transaction_active & in_txn;
    assign accept   = data_strobe & transaction_active & ~direction_in & ep_ok;
    assign cnt_eff  = start ? '0 : count;
    assign has_room = cnt_eff < DEPTH_L;
    assign commit   = end_t & success & ~direction_in & ep_ok;
    assign do_match = commit & setup & (endpoint == 4'd0) & (count == SETUP_L) & ~ovf_txn;

    // First SETUP byte lands in the most significant byte of the compare word.
    always_comb begin
        setup_word = '0;
        for (int i = 0; i < 8; i++) begin
            setup_word[63-8*i -: 8] = stage[i];
        end
    end

    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_MATCH; k++) begin
            hit[k] = (((setup_word ^ match_pattern[64*k +: 64]) & match_mask[64*k +: 64]) == 64'd0);
        end
    end

    always_comb begin
        low_idx = '0;
        for (int k = NUM_MATCH - 1; k >= 0; k--) begin
            if (hit[k]) low_idx = MW'(k);
        end
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            ta_q      <= 1'b0;
            sync_q    <= 1'b0;
            in_txn    <= 1'b0;
            ovf_txn   <= 1'b0;
            count     <= '0;
            valid_q   <= '0;
            ovf       <= 1'b0;
            pkt_v     <= 1'b0;
            pkt_ep    <= '0;
            pkt_len   <= '0;
            pkt_setup <= 1'b0;
            match_v   <= 1'b0;
            match_idx <= '0;
            match_vec <= '0;
            rd_data   <= '0;
            rd_len    <= '0;
            rd_valid  <= 1'b0;
            for (int e = 0; e < NUM_EP; e++) len_q[e] <= '0;
        end else begin
            ta_q <= transaction_active;
            if (!transaction_active) sync_q <= 1'b1;

            if (usb_rst) begin
                in_txn    <= 1'b0;
                ovf_txn   <= 1'b0;
                count     <= '0;
                valid_q   <= '0;
                ovf       <= 1'b0;
                pkt_v     <= 1'b0;
                match_v   <= 1'b0;
                match_vec <= '0;
            end else begin
                if (start)                   in_txn <= 1'b1;
                else if (!transaction_active) in_txn <= 1'b0;

                count <= (accept && has_room) ? cnt_eff + LW'(1) : cnt_eff;
                if (start) ovf_txn <= 1'b0;
                if (accept && !has_room) begin
                    ovf_txn <= 1'b1;
                    ovf     <= 1'b1;
                end

                pkt_v   <= commit;
                match_v <= 1'b0;
                if (commit) begin
                    pkt_ep          <= endpoint;
                    pkt_len         <= count;
                    pkt_setup       <= setup;
                    len_q[endpoint] <= count;
                    valid_q[endpoint] <= 1'b1;
                    if (setup && endpoint == 4'd0) begin
                        if (do_match) begin
                            match_vec <= hit;
                            match_v   <= |hit;
                            match_idx <= low_idx;
                        end else begin
                            match_vec <= '0;
                            match_idx <= '0;
                        end
                    end
                end
            end

            // Reads sample pre-commit contents when a commit lands this cycle.
            rd_data  <= rd_ok ? mem[rd_ep][rd_idx] : 8'd0;
            rd_len   <= rd_ok ? len_q[rd_ep] : '0;
            rd_valid <= rd_ok & valid_q[rd_ep];
        end
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            for (int e = 0; e < NUM_EP; e++) begin
                for (int i = 0; i < DEPTH; i++) mem[e][i] <= '0;
            end
        end else if (!usb_rst) begin
            if (accept && has_room) stage[cnt_eff[IW-1:0]] <= data_out;
            if (commit) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (LW'(i) < count) mem[endpoint][i] <= stage[i];
                end
            end
        end
    end

endmodule

// File: doc/usb_ep_capture.md
Name: usb_ep_capture

Overview:
- Parametrised per-endpoint packet capture and SETUP-request matcher.
- Sits beside the `usb` core in `usb_top`, on the core's receive-side outputs.
- Stages OUT/SETUP data bytes for the current transaction. On a successful transaction it commits them to a per-endpoint buffer, readable through a registered read port.
- Compares each committed 8-byte SETUP packet against NUM_MATCH masked patterns. Matches are reported as a pulse and as held level flags.

Parameters:
- NUM_EP, 16: number of endpoints captured; endpoint numbers >= NUM_EP are ignored.
- DEPTH, 8: bytes stored per endpoint (>= 8).
- NUM_MATCH, 4: number of SETUP pattern comparators.
- LW, $clog2(DEPTH+1): width of length fields (derived; do not override).

Ports:
- clk48, in, 1: 48 MHz clock.
- rst_n, in, 1: asynchronous active-low reset.
- usb_rst, in, 1: bus reset from core; synchronous clear.
- transaction_active, in, 1: core transaction window.
- endpoint, in, 4: endpoint of current transaction.
- setup, in, 1: current transaction is SETUP.
- direction_in, in, 1: current transaction is IN (host read).
- data_strobe, in, 1: data_out valid this cycle.
- data_out, in, 8: received byte.
- success, in, 1: transaction handshake OK; sampled at end of transaction.
- match_pattern, in, NUM_MATCH*64: pattern k at bits [64k+63:64k]; first SETUP byte in the MSB byte.
- match_mask, in, NUM_MATCH*64: 1 = bit compared, 0 = don't care.
- rd_ep, in, 4: read-port endpoint.
- rd_idx, in, $clog2(DEPTH): read-port byte index.
- rd_data, out, 8: committed byte, 1-cycle latency.
- rd_len, out, LW: committed length of rd_ep, 1-cycle latency.
- rd_valid, out, 1: rd_ep holds a committed packet, 1-cycle latency.
- pkt_v, out, 1: one-cycle commit pulse.
- pkt_ep, out, 4: endpoint of committed packet.
- pkt_len, out, LW: bytes committed.
- pkt_setup, out, 1: committed packet was SETUP.
- ovf, out, 1: sticky; a transaction delivered more than DEPTH bytes.
- match_v, out, 1: one-cycle pulse, SETUP commit hit >= 1 pattern.
- match_idx, out, $clog2(NUM_MATCH): lowest-index hit.
- match_vec, out, NUM_MATCH: held hit flags for the latest SETUP on ep 0.

Behaviour:
- Reset (rst_n low, async): all outputs 0; all buffers and valid flags, staging count and previous-transaction_active register cleared.
- Start of transaction (transaction_active 0->1 vs registered copy): staging count <= 0. If data_strobe is high in the same cycle, the byte is written at index 0 and count <= 1.
- Byte accept: data_strobe & transaction_active & !direction_in & endpoint < NUM_EP.
  - count < DEPTH: staging[count] <= data_out; count++.
  - Otherwise: byte dropped, transaction marked overflowed, ovf <= 1 (sticky until rst_n or usb_rst).
  - data_strobe while transaction_active = 0 is ignored.
- End of transaction (transaction_active 1->0), all conditions below evaluated in that cycle:
  - Commit if success = 1, !direction_in and endpoint < NUM_EP. Otherwise staging is discarded: no pulse, no buffer change.
  - Commit copies staging[0..count-1] into buffer[endpoint] and sets len[endpoint] <= count and valid[endpoint] <= 1. Bytes beyond count keep stale data.
  - pkt_v/pkt_ep/pkt_len/pkt_setup are registered and asserted the cycle after the end cycle.
  - A zero-length commit is legal: pkt_len = 0, valid set.
- Matching is done only on a commit with setup = 1, endpoint = 0, count = 8 and not overflowed.
  - Word W = {staging[0], ..., staging[7]}; hit[k] = ((W ^ pattern_k) & mask_k) == 0.
  - match_vec <= hit; match_v <= |hit; match_idx <= lowest k with hit[k] (0 if none). All updated in the same cycle as pkt_v.
  - Any other ep-0 SETUP commit sets match_vec <= 0, match_v = 0.
  - Commits on other endpoints leave match_vec unchanged.
- Read port: rd_data/rd_len/rd_valid are registered from rd_ep/rd_idx. If a commit to rd_ep occurs in the same cycle, the read returns pre-commit contents. An rd_ep >= NUM_EP returns 0s.
- usb_rst (synchronous, priority over everything except rst_n):
  - Clears valid[], ovf, match_vec, staging count and pulses.
  - Buffer contents are not cleared.
- rst_n asserted mid-transaction: the transaction is lost. After release, the next 1->0 edge of transaction_active is only acted on if the 0->1 edge was also seen after release.
- All widths unsigned. count saturates at DEPTH and never wraps.

Test Plan:
- GET_DESCRIPTOR: pattern0 = 64'h8006000100004000, mask0 all ones; SETUP ep0 with those 8 bytes, success = 1 -> pkt_v, pkt_ep = 0, pkt_len = 8, pkt_setup = 1, match_v = 1, match_idx = 0, match_vec = 4'b0001.
- Masking: pattern1 = 64'h8006000000000000, mask1 = 64'hFFFF000000000000; SETUP bytes 80 06 00 02 00 00 FF 00 -> match_vec = 4'b0010, match_idx = 1. A following SETUP with bytes 00 05 ... -> match_vec = 0, match_v = 0.
- Failed or IN transaction: OUT ep3 with 4 bytes and success = 0, then an IN ep3 -> no pkt_v; rd_ep = 3 gives rd_valid = 0.
- Overflow: OUT ep2 with DEPTH+3 bytes, success = 1 -> pkt_len = DEPTH, ovf = 1; rd_idx 0..DEPTH-1 return the first DEPTH bytes.
- Readback and same-cycle collision: commit ep5 with A0 A1, then read idx 1 while a second ep5 commit of B0 B1 lands -> A1 returned; next read -> B1.
- usb_rst after a match, and rst_n low mid-transaction -> match_vec = 0, ovf = 0, rd_valid = 0 for all endpoints; no pkt_v on the aborted transaction's end.
